// File: rtl/inst_loader.sv
// Boot-time instruction memory writer: parses an A5-framed program image from a
// byte stream, writes it word by word, and releases the CPU once the checksum matches.
module inst_loader #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 4096,
    parameter int                    TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] wraddress,
    output logic [15:0]           data,
    output logic                  wren,
    output logic                  cpu_rst_n,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [7:0]    START_BYTE = 8'hA5;
    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [16:0]   MAX_LEN    = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            chk_q, chk_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           data_q, data_d;
    logic                  wren_q, wren_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [15:0]           len_new;
    logic                  in_frame;
    logic                  timed_out;

    assign in_frame = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hi_d        = hi_q;
        chk_d       = chk_q;
        word_cnt_d  = word_cnt_q;
        tmo_d       = '0;
        addr_d      = addr_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        cpu_rst_n_d = (state_q == S_DONE);
        len_new     = {len_q[15:8], rx_data};
        timed_out   = 1'b0;

        // The address advances in the cycle the write is presented, so the
        // memory sees the pre-increment address alongside wren.
        if (wren_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        if (in_frame) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                timed_out = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (rx_valid && rx_data == START_BYTE) begin
                    state_d    = S_LEN_HI;
                    chk_d      = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    addr_d     = BASE_ADDR;
                    word_cnt_d = '0;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d = len_new;
                    if ({1'b0, len_new} > MAX_LEN) begin
                        state_d = S_ERROR;
                    end else if (len_new == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (rx_valid) begin
                    chk_d      = chk_q ^ rx_data;
                    data_d     = {hi_q, rx_data};
                    wren_d     = 1'b1;
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (word_cnt_q + 16'd1 == len_q) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    state_d = (rx_data == chk_q) ? S_DONE : S_ERROR;
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase

        if (timed_out) begin
            state_d = S_ERROR;
        end

        if (state_d == S_ERROR && state_q != S_ERROR) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
        end
        if (state_d == S_DONE && state_q != S_DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            hi_q        <= '0;
            chk_q       <= '0;
            word_cnt_q  <= '0;
            tmo_q       <= '0;
            addr_q      <= BASE_ADDR;
            data_q      <= '0;
            wren_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            chk_q       <= chk_d;
            word_cnt_q  <= word_cnt_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign wraddress = addr_q;
    assign data      = data_q;
    assign wren      = wren_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign load_busy = busy_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed frames from the test plan followed by
// randomized frames checked against a queue-based model of the image format.
module tb_inst_loader;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [15:0] wraddress;
   logic [15:0] data;
   logic        wren;
   logic        cpu_rst_n;
   logic        load_busy;
   logic        load_done;
   logic        load_err;

   int          checkCount = 0;
   int          passCount  = 0;

   logic [15:0] frameWords[$];
   int          nWords;
   bit          badFrame;
   bit          gotDone;
   logic [7:0]  noiseByte;

   always #5 clk = ~clk;

   inst_loader #(
      .ADDR_WIDTH(16),
      .BASE_ADDR (16'd0),
      .MAX_WORDS (4096),
      .TIMEOUT   (TMO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .wraddress(wraddress),
      .data     (data),
      .wren     (wren),
      .cpu_rst_n(cpu_rst_n),
      .load_busy(load_busy),
      .load_done(load_done),
      .load_err (load_err)
   );

   // Every comparison funnels through here so the pass/total counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic checkStatus(input string tag, input logic expBusy, input logic expDone,
                              input logic expErr, input logic expCpu);
      checkOutput({tag, "_busy"}, 32'(load_busy), 32'(expBusy));
      checkOutput({tag, "_done"}, 32'(load_done), 32'(expDone));
      checkOutput({tag, "_err"},  32'(load_err),  32'(expErr));
      checkOutput({tag, "_cpu"},  32'(cpu_rst_n), 32'(expCpu));
   endtask

   // Drives one byte for a single cycle; a write, if any, must appear exactly one cycle later.
   task automatic applyStimulus(input logic [7:0] b, input bit expWr,
                                input logic [15:0] expAddr, input logic [15:0] expData);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      checkOutput("wren", 32'(wren), 32'(expWr));
      if (expWr) begin
         checkOutput("wraddress", 32'(wraddress), 32'(expAddr));
         checkOutput("data", 32'(data), 32'(expData));
      end
   endtask

   task automatic idleCycles(input int n);
      int seen;
      seen     = 0;
      rx_valid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (wren) seen++;
      end
      checkOutput("idle_wren", 32'(seen), 32'd0);
   endtask

   task automatic doReset();
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Model: a frame is A5, length, words high byte first, then the XOR of the data bytes.
   task automatic sendFrame(input bit corrupt, input int maxGap);
      logic [7:0]  chk;
      logic [15:0] len;
      int          gap;
      chk = 8'h00;
      len = 16'(frameWords.size());
      foreach (frameWords[i]) chk = chk ^ frameWords[i][15:8] ^ frameWords[i][7:0];
      if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
      applyStimulus(8'hA5, 1'b0, 16'h0, 16'h0);
      applyStimulus(len[15:8], 1'b0, 16'h0, 16'h0);
      applyStimulus(len[7:0], 1'b0, 16'h0, 16'h0);
      foreach (frameWords[i]) begin
         gap = $urandom_range(0, maxGap);
         if (gap > 0) idleCycles(gap);
         applyStimulus(frameWords[i][15:8], 1'b0, 16'h0, 16'h0);
         applyStimulus(frameWords[i][7:0], 1'b1, 16'(i), frameWords[i]);
      end
      gap = $urandom_range(0, maxGap);
      if (gap > 0) idleCycles(gap);
      applyStimulus(chk, 1'b0, 16'h0, 16'h0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired before the bench finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset values
      checkOutput("rst_wraddress", 32'(wraddress), 32'h0);
      checkOutput("rst_data", 32'(data), 32'h0);
      checkOutput("rst_wren", 32'(wren), 32'h0);
      checkStatus("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      idleCycles(2);

      // Normal two-word load
      applyStimulus(8'hA5, 1'b0, 16'h0, 16'h0);
      checkStatus("norm_start", 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h02, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h12, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h34, 1'b1, 16'h0000, 16'h1234);
      applyStimulus(8'hAB, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'hCD, 1'b1, 16'h0001, 16'hABCD);
      applyStimulus(8'h40, 1'b0, 16'h0, 16'h0);
      checkStatus("norm_done", 1'b0, 1'b1, 1'b0, 1'b0);
      idleCycles(1);
      checkStatus("norm_cpu", 1'b0, 1'b1, 1'b0, 1'b1);

      // Once done, further frames are ignored
      applyStimulus(8'hA5, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h01, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h11, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h22, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h33, 1'b0, 16'h0, 16'h0);
      checkStatus("sticky_done", 1'b0, 1'b1, 1'b0, 1'b1);

      // Bad checksum, then the correct frame
      doReset();
      checkStatus("bad_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'hA5, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h02, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h12, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h34, 1'b1, 16'h0000, 16'h1234);
      applyStimulus(8'hAB, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'hCD, 1'b1, 16'h0001, 16'hABCD);
      applyStimulus(8'h41, 1'b0, 16'h0, 16'h0);
      checkStatus("bad_chk", 1'b0, 1'b0, 1'b1, 1'b0);
      idleCycles(2);
      checkStatus("bad_hold", 1'b0, 1'b0, 1'b1, 1'b0);
      frameWords = '{16'h1234, 16'hABCD};
      applyStimulus(8'hA5, 1'b0, 16'h0, 16'h0);
      checkStatus("retry_start", 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h02, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h12, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h34, 1'b1, 16'h0000, 16'h1234);
      applyStimulus(8'hAB, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'hCD, 1'b1, 16'h0001, 16'hABCD);
      applyStimulus(8'h40, 1'b0, 16'h0, 16'h0);
      idleCycles(1);
      checkStatus("retry_done", 1'b0, 1'b1, 1'b0, 1'b1);

      // Oversize length, ignored data, then zero-length frames
      doReset();
      applyStimulus(8'hA5, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h10, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h01, 1'b0, 16'h0, 16'h0);
      checkStatus("over_err", 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h12, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h34, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h56, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h78, 1'b0, 16'h0, 16'h0);
      checkStatus("over_ignore", 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'hA5, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h07, 1'b0, 16'h0, 16'h0);
      checkStatus("zero_bad", 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'hA5, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      idleCycles(1);
      checkStatus("zero_done", 1'b0, 1'b1, 1'b0, 1'b1);

      // Inter-byte timeout inside a frame
      doReset();
      applyStimulus(8'hA5, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h01, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h12, 1'b0, 16'h0, 16'h0);
      idleCycles(TMO - 2);
      checkStatus("tmo_before", 1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(4);
      checkStatus("tmo_after", 1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a three-word frame
      doReset();
      applyStimulus(8'hA5, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h00, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h03, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h11, 1'b0, 16'h0, 16'h0);
      applyStimulus(8'h11, 1'b1, 16'h0000, 16'h1111);
      applyStimulus(8'h22, 1'b0, 16'h0, 16'h0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_wraddress", 32'(wraddress), 32'h0);
      checkOutput("midrst_data", 32'(data), 32'h0);
      checkOutput("midrst_wren", 32'(wren), 32'h0);
      checkStatus("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idleCycles(1);
      frameWords = '{16'h0F0F, 16'hBEEF, 16'h1357};
      sendFrame(1'b0, 0);
      idleCycles(1);
      checkStatus("midrst_reload", 1'b0, 1'b1, 1'b0, 1'b1);

      // Randomized frames with noise, gaps and occasional corrupted checksums
      doReset();
      gotDone = 1'b0;
      for (int f = 0; f < 8 && !gotDone; f++) begin
         nWords   = $urandom_range(1, 6);
         badFrame = (f < 7) ? ($urandom_range(0, 2) != 0) : 1'b0;
         frameWords.delete();
         repeat (nWords) frameWords.push_back(16'($urandom));
         repeat ($urandom_range(0, 2)) begin
            noiseByte = 8'($urandom);
            if (noiseByte == 8'hA5) noiseByte = 8'h5A;
            applyStimulus(noiseByte, 1'b0, 16'h0, 16'h0);
         end
         sendFrame(badFrame, 2);
         checkStatus("rand_end", 1'b0, !badFrame, badFrame, 1'b0);
         if (!badFrame) begin
            idleCycles(1);
            checkOutput("rand_cpu", 32'(cpu_rst_n), 32'h1);
            gotDone = 1'b1;
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
